// File: rtl/cdb_writeback_arbiter_if.sv
// Completion-side and CDB-side signal bundle for cdb_writeback_arbiter.
// The master modport is the EX/MEM producer view; the slave modport is the arbiter.
interface cdb_writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
);
    logic                  flush;
    logic [3:0]            in_valid;
    logic [4*DATA_W-1:0]   in_value;
    logic [4*32-1:0]       in_pc;
    logic [4*TAG_W-1:0]    in_tag;

    logic                  cdb_valid;
    logic [DATA_W-1:0]     cdb_value;
    logic [31:0]           cdb_pc;
    logic [TAG_W-1:0]      cdb_tag;
    logic [1:0]            cdb_src;
    logic [3:0]            src_full;
    logic [3:0]            overflow;

    modport master (
        output flush, in_valid, in_value, in_pc, in_tag,
        input  cdb_valid, cdb_value, cdb_pc, cdb_tag, cdb_src, src_full, overflow
    );

    modport slave (
        input  flush, in_valid, in_value, in_pc, in_tag,
        output cdb_valid, cdb_value, cdb_pc, cdb_tag, cdb_src, src_full, overflow
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Buffers ALU/MUL/DIV/LOAD completions in per-source FIFOs and grants one per cycle onto the CDB, round-robin.
// Optional macro CDB_BYPASS_EN lets an empty source with a fresh completion compete directly for the bus.
module cdb_writeback_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    cdb_writeback_arbiter_if.slave bus
);

    localparam int NSRC  = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [31:0]       pc;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            fifo_mem [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NSRC];
    logic [PTR_W-1:0]  rd_ptr   [NSRC];
    logic [CNT_W-1:0]  count    [NSRC];
    logic [1:0]        rr_ptr;

    logic              cdb_valid_q;
    entry_t            cdb_q;
    logic [1:0]        cdb_src_q;
    logic [NSRC-1:0]   overflow_q;

    entry_t            in_entry [NSRC];
    logic [NSRC-1:0]   nonempty;
    logic [NSRC-1:0]   candidate;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   drop;
    logic [NSRC-1:0]   full;
    logic              grant_any;
    logic [1:0]        winner;
    logic [1:0]        idx;
    entry_t            grant_entry;
`ifdef CDB_BYPASS_EN
    logic              grant_bypass;
`endif

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            in_entry[i] = {bus.in_value[i*DATA_W +: DATA_W],
                           bus.in_pc[i*32 +: 32],
                           bus.in_tag[i*TAG_W +: TAG_W]};
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == FULL_CNT);
        end
    end

`ifdef CDB_BYPASS_EN
    assign candidate = nonempty | bus.in_valid;
`else
    assign candidate = nonempty;
`endif

    // Round-robin search starting at rr_ptr; first candidate wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        grant_any = 1'b0;
        winner    = rr_ptr;
        idx       = rr_ptr;
        for (int k = 0; k < NSRC; k++) begin
            idx = rr_ptr + 2'(k);
            if (!grant_any && candidate[idx]) begin
                grant_any = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_any && nonempty[winner]) begin
            pop[winner] = 1'b1;
        end
`ifdef CDB_BYPASS_EN
        grant_bypass = grant_any && !nonempty[winner];
        grant_entry  = grant_bypass ? in_entry[winner] : fifo_mem[winner][rd_ptr[winner]];
`else
        grant_entry  = fifo_mem[winner][rd_ptr[winner]];
`endif
        for (int i = 0; i < NSRC; i++) begin
            // A full FIFO still accepts when its head leaves at the same edge.
            push[i] = bus.in_valid[i] && (!full[i] || pop[i]);
            drop[i] = bus.in_valid[i] && full[i] && !pop[i];
`ifdef CDB_BYPASS_EN
            if (grant_bypass && (winner == 2'(i))) begin
                push[i] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register update sees only pre-edge state.
        if (!reset) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            cdb_src_q   <= '0;
            overflow_q  <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                if (drop[i]) overflow_q[i] <= 1'b1;
            end
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_q     <= grant_entry;
                cdb_src_q <= winner;
                rr_ptr    <= winner + 2'd1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; entry validity lives entirely in the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (reset && !bus.flush && push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_entry[i];
            end
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_value = cdb_q.value;
    assign bus.cdb_pc    = cdb_q.pc;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.src_full  = full;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Scoreboard bench for cdb_writeback_arbiter (default build): expected broadcasts are queued
// in hand-computed grant order and a negedge monitor compares every cdb_valid cycle.
module tb_cdb_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [31:0] value;
        logic [31:0] pc;
        logic [7:0]  tag;
        logic [1:0]  src;
    } bc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bc_t  exp_q[$];
    bc_t  mon_exp;

    cdb_writeback_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.in_valid = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic drive(input int src, input logic [31:0] value, input logic [31:0] pc,
                         input logic [7:0] tag);
        bus.in_valid[src]                  = 1'b1;
        bus.in_value[src*DATA_W +: DATA_W] = value;
        bus.in_pc[src*32 +: 32]            = pc;
        bus.in_tag[src*TAG_W +: TAG_W]     = tag;
    endtask

    task automatic expect_bc(input logic [31:0] value, input logic [31:0] pc,
                             input logic [7:0] tag, input logic [1:0] src);
        bc_t e;
        e.value = value;
        e.pc    = pc;
        e.tag   = tag;
        e.src   = src;
        exp_q.push_back(e);
    endtask

    // Monitor: every broadcast must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_broadcast: got value %0h src %0d, expected no broadcast",
                         bus.cdb_value, bus.cdb_src);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cdb_value", 64'(bus.cdb_value), 64'(mon_exp.value));
                check("cdb_pc",    64'(bus.cdb_pc),    64'(mon_exp.pc));
                check("cdb_tag",   64'(bus.cdb_tag),   64'(mon_exp.tag));
                check("cdb_src",   64'(bus.cdb_src),   64'(mon_exp.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected the bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_value = '0;
        bus.in_pc    = '0;
        bus.in_tag   = '0;
        idle();
        tick(2);
        check("rst_valid",    64'(bus.cdb_valid), 64'd0);
        check("rst_value",    64'(bus.cdb_value), 64'd0);
        check("rst_pc",       64'(bus.cdb_pc),    64'd0);
        check("rst_tag",      64'(bus.cdb_tag),   64'd0);
        check("rst_src",      64'(bus.cdb_src),   64'd0);
        check("rst_src_full", 64'(bus.src_full),  64'd0);
        check("rst_overflow", 64'(bus.overflow),  64'd0);
        reset = 1'b1;

        // Single ALU result: visible after the second edge, gone after the third.
        expect_bc(32'hAA, 32'h100, 8'h05, 2'd0);
        drive(0, 32'hAA, 32'h100, 8'h05);
        tick(); idle();
        check("single_valid_e1", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("single_valid_e2", 64'(bus.cdb_valid), 64'd1);
        tick();
        check("single_valid_e3", 64'(bus.cdb_valid), 64'd0);

        // Re-reset so the round-robin burst starts from rr_ptr = 0.
        reset = 1'b0; tick(); reset = 1'b1;

        // Two bursts of all four sources: grant order 0,1,2,3 both times.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                expect_bc(32'((i + 1) * 16 + b), 32'(32'h200 + i * 4), 8'(8'h20 + i), 2'(i));
                drive(i, 32'((i + 1) * 16 + b), 32'(32'h200 + i * 4), 8'(8'h20 + i));
            end
            tick(); idle();
            check("rr_src_full_burst", 64'(bus.src_full), 64'd0);
            tick(4);
        end
        tick();
        check("rr_drained", 64'(bus.cdb_valid), 64'd0);

        // MUL alone moves rr_ptr to 2, so a later DIV+ALU pair grants DIV first.
        expect_bc(32'h35, 32'h335, 8'h35, 2'd1);
        drive(1, 32'h35, 32'h335, 8'h35);
        tick(); idle(); tick();
        expect_bc(32'h36, 32'h336, 8'h36, 2'd2);
        expect_bc(32'h37, 32'h337, 8'h37, 2'd0);
        drive(2, 32'h36, 32'h336, 8'h36);
        drive(0, 32'h37, 32'h337, 8'h37);
        tick(); idle(); tick(2);
        tick();
        check("fair_drained", 64'(bus.cdb_valid), 64'd0);

        // Overflow on MUL (rr_ptr = 1): DIV, LOAD, ALU win while MUL fills, third push dropped.
        expect_bc(32'hD1, 32'h4D1, 8'h41, 2'd2);
        expect_bc(32'hD3, 32'h4D3, 8'h43, 2'd3);
        expect_bc(32'hA1, 32'h4A1, 8'h40, 2'd0);
        expect_bc(32'h1,  32'h401, 8'h51, 2'd1);
        expect_bc(32'h2,  32'h402, 8'h52, 2'd1);
        drive(2, 32'hD1, 32'h4D1, 8'h41);
        drive(3, 32'hD3, 32'h4D3, 8'h43);
        tick(); idle();
        drive(0, 32'hA1, 32'h4A1, 8'h40);
        drive(1, 32'h1,  32'h401, 8'h51);
        tick(); idle();
        drive(1, 32'h2,  32'h402, 8'h52);
        tick(); idle();
        check("ovf_full_before", 64'(bus.src_full), 64'h2);
        check("ovf_clear_before", 64'(bus.overflow), 64'h0);
        drive(1, 32'h3,  32'h403, 8'h53);
        tick(); idle();
        check("ovf_set",       64'(bus.overflow), 64'h2);
        check("ovf_full_held", 64'(bus.src_full), 64'h2);
        tick(3);
        check("ovf_drained",   64'(bus.cdb_valid), 64'd0);
        check("ovf_sticky",    64'(bus.overflow),  64'h2);
        check("ovf_full_gone", 64'(bus.src_full),  64'h0);

        // DIV full and granted while pushing 0x77: accepted, no overflow, broadcast last.
        expect_bc(32'h61, 32'h561, 8'h61, 2'd3);
        expect_bc(32'h62, 32'h562, 8'h62, 2'd0);
        expect_bc(32'h51, 32'h551, 8'h71, 2'd2);
        expect_bc(32'h52, 32'h552, 8'h72, 2'd2);
        expect_bc(32'h77, 32'h577, 8'h77, 2'd2);
        drive(3, 32'h61, 32'h561, 8'h61);
        tick(); idle();
        drive(0, 32'h62, 32'h562, 8'h62);
        drive(2, 32'h51, 32'h551, 8'h71);
        tick(); idle();
        drive(2, 32'h52, 32'h552, 8'h72);
        tick(); idle();
        check("pp_div_full", 64'(bus.src_full), 64'h4);
        drive(2, 32'h77, 32'h577, 8'h77);
        tick(); idle();
        check("pp_still_full", 64'(bus.src_full), 64'h4);
        check("pp_no_ovf",     64'(bus.overflow), 64'h2);
        tick(2);
        tick();
        check("pp_drained", 64'(bus.cdb_valid), 64'd0);

        // Reset mid-burst: one ALU entry goes out, then reset wipes the rest.
        expect_bc(32'h71, 32'h671, 8'h81, 2'd0);
        drive(0, 32'h71, 32'h671, 8'h81);
        drive(1, 32'h72, 32'h672, 8'h82);
        drive(2, 32'h73, 32'h673, 8'h83);
        tick(); idle();
        drive(0, 32'h74, 32'h674, 8'h84);
        tick(); idle();
        check("mid_valid_before_rst", 64'(bus.cdb_valid), 64'd1);
        reset = 1'b0;
        drive(3, 32'h75, 32'h675, 8'h85);
        tick(); idle();
        check("mid_rst_valid",    64'(bus.cdb_valid), 64'd0);
        check("mid_rst_value",    64'(bus.cdb_value), 64'd0);
        check("mid_rst_pc",       64'(bus.cdb_pc),    64'd0);
        check("mid_rst_tag",      64'(bus.cdb_tag),   64'd0);
        check("mid_rst_src_full", 64'(bus.src_full),  64'd0);
        check("mid_rst_overflow", 64'(bus.overflow),  64'd0);
        reset = 1'b1;
        tick();
        check("mid_after_rst_idle", 64'(bus.cdb_valid), 64'd0);
        expect_bc(32'h76, 32'h676, 8'h86, 2'd0);
        drive(0, 32'h76, 32'h676, 8'h86);
        tick(); idle(); tick();
        check("mid_fresh_valid", 64'(bus.cdb_valid), 64'd1);
        check("mid_fresh_src",   64'(bus.cdb_src),   64'd0);
        tick();

        // Flush with two ALU and one LOAD buffered (rr_ptr = 1): only the DIV entry escapes.
        expect_bc(32'h84, 32'h784, 8'h94, 2'd2);
        drive(0, 32'h81, 32'h781, 8'h91);
        drive(2, 32'h84, 32'h784, 8'h94);
        drive(3, 32'h83, 32'h783, 8'h93);
        tick(); idle();
        drive(0, 32'h82, 32'h782, 8'h92);
        tick(); idle();
        bus.flush = 1'b1;
        drive(1, 32'h85, 32'h785, 8'h95);
        drive(0, 32'h86, 32'h786, 8'h96);
        tick(); idle();
        check("flush_valid",    64'(bus.cdb_valid), 64'd0);
        check("flush_src_full", 64'(bus.src_full),  64'd0);
        check("flush_overflow", 64'(bus.overflow),  64'd0);
        tick(3);
        check("flush_quiet", 64'(bus.cdb_valid), 64'd0);

        // After flush rr_ptr is 0, so ALU beats LOAD.
        expect_bc(32'h91, 32'h891, 8'hA1, 2'd0);
        expect_bc(32'h93, 32'h893, 8'hA3, 2'd3);
        drive(0, 32'h91, 32'h891, 8'hA1);
        drive(3, 32'h93, 32'h893, 8'hA3);
        tick(); idle(); tick(2);
        tick();
        check("final_idle", 64'(bus.cdb_valid), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Sits directly downstream of the EX/MEM pipeline register and consumes its per-unit completion outputs.
- Those outputs are ALU, MUL and DIV exec value/PC/done, plus the load result.
- Buffers each source's completions in a small per-source FIFO, because the sources have no backpressure.
- Each cycle, grants one entry round-robin onto the common data bus (CDB) that feeds the ROB and reservation stations.
- ROB flush discards all buffered results.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, minimum 2.
- DATA_W, 32, result value width.
- TAG_W, 8, physical register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- flush  in  1  ROB flush; discards all buffered and in-flight results.
- in_valid  in  4  per-source completion strobe; index 0=ALU, 1=MUL, 2=DIV, 3=LOAD.
- in_value  in  4*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
- in_pc  in  4*32  per-source instruction PC; source i occupies bits [i*32 +: 32].
- in_tag  in  4*TAG_W  per-source destination physical tag.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_value  out  DATA_W  broadcast result.
- cdb_pc  out  32  broadcast PC.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_src  out  2  index of the granted source.
- src_full  out  4  per-source FIFO full (count==DEPTH).
- overflow  out  4  sticky per-source overflow error.

Behaviour:
- Reset (reset==0 at clk edge):
  - All FIFO pointers and counts = 0.
  - rr_ptr = 0.
  - cdb_valid = 0; cdb_value, cdb_pc, cdb_tag = 0; cdb_src = 0.
  - src_full = 0; overflow = 0.
  - Reset has priority over flush and over all pushes.
- Push:
  - in_valid[i]==1 at an edge writes {value, pc, tag} of source i into FIFO i.
  - The push is accepted if count_i < DEPTH, or if FIFO i is popped at the same edge.
  - Otherwise the entry is dropped and overflow[i] is set; it stays set until reset.
- Arbitration:
  - Candidates are the non-empty FIFOs, using counts and contents from before the edge.
  - Search order starts at rr_ptr and wraps modulo 4.
  - The first non-empty FIFO wins; its head is popped and loaded into the cdb_* registers.
  - cdb_valid=1 and cdb_src=winner; rr_ptr <= (winner+1) mod 4.
  - With no candidate: cdb_valid <= 0, cdb_value/pc/tag hold their previous values, and rr_ptr holds.
- Latency: a push at edge k into an empty FIFO appears on the CDB after edge k+1 at the earliest.
- Throughput: one broadcast per cycle.
- Order: FIFO order is preserved within a source; there is no ordering guarantee across sources.
- Simultaneous push and pop on the same FIFO: count is unchanged; this is legal even when full.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Flush (flush==1, reset==1):
  - All counts and pointers clear; cdb_valid <= 0.
  - Pushes at the same edge are dropped without setting overflow.
  - rr_ptr <= 0.
- src_full is a combinational decode of the registered counts.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined:
  - A source whose FIFO is empty and whose in_valid==1 is also a candidate at that edge.
  - It joins the same round-robin order.
  - If it wins, the input goes straight to the cdb_* registers, is not pushed, and latency becomes 1 edge.
  - If it loses, it is pushed normally.
- When undefined: behaviour is exactly as above, with minimum latency 2 edges.

Test Plan:
- Single ALU result: in_valid=0001, value=0x0000_00AA, pc=0x100, tag=0x05 at edge 1 -> after edge 2: cdb_valid=1, value=0xAA, pc=0x100, tag=0x05, src=0; after edge 3: cdb_valid=0. With CDB_BYPASS_EN, the same values appear after edge 1.
- Round-robin: all four sources push once at edge 1 (values 0x10, 0x20, 0x30, 0x40) -> broadcasts after edges 2-5 with src 0, 1, 2, 3 in order. A second burst of all four then starts from src 0 again, since rr_ptr wrapped.
- Overflow (DEPTH=2): MUL pushes 0x1, 0x2, 0x3 on consecutive edges while ALU is busy -> a third push into a full MUL FIFO that is not popped at that edge leaves overflow[1]=1 and src_full[1]=1. The stored MUL values are broadcast in order 0x1 then 0x2. overflow[1] stays 1 until reset.
- Push and pop while full: with the DIV FIFO full and DIV granted, push 0x77 at the same edge -> no overflow, count stays 2, and 0x77 is broadcast after the older entries.
- Flush: two ALU and one LOAD entries buffered; assert flush with a MUL push at the same edge -> next cycle cdb_valid=0, src_full=0, overflow=0. No buffered entry or the MUL value is ever broadcast.
- Reset mid-burst: drive reset=0 for one edge while FIFOs hold entries and cdb_valid=1 -> all outputs return to 0. A push at that edge is ignored. A fresh ALU push afterwards is broadcast with src=0.
